// File: rtl/mac_feed_ctrl_pkg.sv
// Shared definitions for the MAC array row feeder: FSM encoding, word width and drain timing.
package mac_feed_ctrl_pkg;

   localparam int WORD_W = 32;

   localparam int ROWS_DEF      = 4;
   localparam int BPW_DEF       = 4;
   localparam int DRAIN_CYC_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2
   } feedState_e;

   // Cycles from the end of the last tile until every row buffer has shifted out.
   function automatic int drainLen(input int rows, input int bpw, input int drainCyc);
      return rows - 1 + bpw + drainCyc;
   endfunction

   localparam int DRAIN_LEN = drainLen(ROWS_DEF, BPW_DEF, DRAIN_CYC_DEF);

endpackage

// File: rtl/mac_feed_ctrl_if.sv
// Command, operand-memory and row-buffer signals of the MAC row feeder.
interface mac_feed_ctrl_if #(
   parameter int ROWS   = 4,
   parameter int ADDR_W = 10,
   parameter int TILE_W = 8
);
   import mac_feed_ctrl_pkg::*;

   logic                     start;
   logic                     abort;
   logic [ADDR_W-1:0]        baseAddr;
   logic [TILE_W-1:0]        numTiles;
   logic                     memRdEn;
   logic [ADDR_W-1:0]        memAddr;
   logic [ROWS*WORD_W-1:0]   memRdata;
   logic [ROWS-1:0]          rowEn;
   logic [ROWS*WORD_W-1:0]   rowWord;
   logic                     busy;
   logic                     done;

   // The feeder is the master: it owns the memory read port and the row-buffer loads.
   modport master (
      input  start, abort, baseAddr, numTiles, memRdata,
      output memRdEn, memAddr, rowEn, rowWord, busy, done
   );

   modport slave (
      output start, abort, baseAddr, numTiles, memRdata,
      input  memRdEn, memAddr, rowEn, rowWord, busy, done
   );

endinterface

// File: rtl/mac_feed_skew.sv
// Triangular delay line: lane r delays its {enable, word} by r cycles to form the systolic wavefront.
module mac_feed_skew
   import mac_feed_ctrl_pkg::*;
#(
   parameter int ROWS = 4
)(
   input  logic                   clk,
   input  logic                   clear_i,
   input  logic                   issueEn_i,
   input  logic [ROWS*WORD_W-1:0] issueWord_i,
   output logic [ROWS-1:0]        laneEn_o,
   output logic [ROWS*WORD_W-1:0] laneWord_o
);

   assign laneEn_o[0]              = issueEn_i;
   assign laneWord_o[WORD_W-1:0]   = issueWord_i[WORD_W-1:0];

   for (genvar r = 1; r < ROWS; r++) begin : gLane
      logic              enPipe_q   [r];
      logic [WORD_W-1:0] wordPipe_q [r];

      // Only slice r travels down lane r, so each stage holds a single 32-bit word.
      always_ff @(posedge clk) begin
         if (clear_i) begin
            for (int k = 0; k < r; k++) begin
               enPipe_q[k]   <= 1'b0;
               wordPipe_q[k] <= '0;
            end
         end else begin
            enPipe_q[0]   <= issueEn_i;
            wordPipe_q[0] <= issueWord_i[r*WORD_W +: WORD_W];
            for (int k = 1; k < r; k++) begin
               enPipe_q[k]   <= enPipe_q[k-1];
               wordPipe_q[k] <= wordPipe_q[k-1];
            end
         end
      end

      assign laneEn_o[r]                    = enPipe_q[r-1];
      assign laneWord_o[r*WORD_W +: WORD_W] = wordPipe_q[r-1];
   end

endmodule

// File: rtl/mac_feed_ctrl.sv
// MAC array row feeder: fetches one operand word per tile and issues skewed row-buffer loads.
// Optional FEED_PERF_EN adds the perfCycles_o busy-cycle counter.
module mac_feed_ctrl
   import mac_feed_ctrl_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int BPW       = 4,
   parameter int ADDR_W    = 10,
   parameter int TILE_W    = 8,
   parameter int DRAIN_CYC = 2
)(
   input  logic            clk,
   input  logic            rst,
   mac_feed_ctrl_if.master bus
`ifdef FEED_PERF_EN
   ,
   output logic [31:0]     perfCycles_o
`endif
);

   localparam int DLEN  = drainLen(ROWS, BPW, DRAIN_CYC);
   localparam int PH_W  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int CNT_W = $clog2(DLEN + 1);

   feedState_e          state_q, state_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [TILE_W-1:0]   tile_q, tile_d;
   logic [TILE_W-1:0]   num_q, num_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    drainCnt_q, drainCnt_d;
   logic                done_q, done_d;
   logic                rdPend_q, rdPend_d;

   logic                memRdEn;
   logic                busy;
   logic [ROWS-1:0]        laneEn;
   logic [ROWS*WORD_W-1:0] laneWord;
   logic [ROWS*WORD_W-1:0] hold_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ph_q       <= '0;
         tile_q     <= '0;
         num_q      <= '0;
         base_q     <= '0;
         drainCnt_q <= '0;
         done_q     <= 1'b0;
         rdPend_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         tile_q     <= tile_d;
         num_q      <= num_d;
         base_q     <= base_d;
         drainCnt_q <= drainCnt_d;
         done_q     <= done_d;
         rdPend_q   <= rdPend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      tile_d     = tile_q;
      num_d      = num_q;
      base_d     = base_q;
      drainCnt_d = drainCnt_q;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Abort outranks Start; a zero-tile request completes without touching memory.
            if (bus.start && !bus.abort) begin
               if (bus.numTiles != '0) begin
                  state_d = ST_FEED;
                  base_d  = bus.baseAddr;
                  num_d   = bus.numTiles;
                  tile_d  = '0;
                  ph_d    = '0;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         ST_FEED: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (ph_q == PH_W'(BPW - 1)) begin
               ph_d = '0;
               if (tile_q == num_q - TILE_W'(1)) begin
                  state_d    = ST_DRAIN;
                  drainCnt_d = '0;
               end else begin
                  tile_d = tile_q + TILE_W'(1);
               end
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         ST_DRAIN: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (drainCnt_q == CNT_W'(DLEN - 1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               drainCnt_d = drainCnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign memRdEn  = (state_q == ST_FEED) && (ph_q == '0);
   assign busy     = (state_q != ST_IDLE);
   // A read aborted in its own cycle must not turn into a row-0 load when its data returns.
   assign rdPend_d = memRdEn && !bus.abort;

   assign bus.memRdEn = memRdEn;
   assign bus.memAddr = memRdEn ? (base_q + ADDR_W'(tile_q)) : '0;
   assign bus.busy    = busy;
   assign bus.done    = done_q;

   mac_feed_skew #(
      .ROWS (ROWS)
   ) uSkew (
      .clk         (clk),
      .clear_i     (rst | bus.abort),
      .issueEn_i   (rdPend_q),
      .issueWord_i (bus.memRdata),
      .laneEn_o    (laneEn),
      .laneWord_o  (laneWord)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (laneEn[r]) begin
               hold_q[r*WORD_W +: WORD_W] <= laneWord[r*WORD_W +: WORD_W];
            end
         end
      end
   end

   // Each row word follows its lane while loading and otherwise keeps the last value loaded.
   for (genvar r = 0; r < ROWS; r++) begin : gRowOut
      assign bus.rowWord[r*WORD_W +: WORD_W] =
         laneEn[r] ? laneWord[r*WORD_W +: WORD_W] : hold_q[r*WORD_W +: WORD_W];
   end
   assign bus.rowEn = laneEn;

`ifdef FEED_PERF_EN
   logic        startAcc;
   logic [31:0] perf_q;

   assign startAcc = (state_q == ST_IDLE) && bus.start && !bus.abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else if (startAcc) begin
         perf_q <= '0;
      end else if (busy) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perfCycles_o = perf_q;
`endif

endmodule

// File: tb/tb_mac_feed_ctrl.sv
// Directed self-checking bench for mac_feed_ctrl; define FEED_PERF_EN to also cover perfCycles_o.
module tb_mac_feed_ctrl;

   localparam int ROWS      = 4;
   localparam int BPW       = 4;
   localparam int ADDR_W    = 10;
   localparam int TILE_W    = 8;
   localparam int DRAIN_CYC = 2;
   localparam int DLEN      = 9;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   mac_feed_ctrl_if #(.ROWS(ROWS), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) bus ();

`ifdef FEED_PERF_EN
   logic [31:0] perfCycles;
`endif

   mac_feed_ctrl #(
      .ROWS      (ROWS),
      .BPW       (BPW),
      .ADDR_W    (ADDR_W),
      .TILE_W    (TILE_W),
      .DRAIN_CYC (DRAIN_CYC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.master)
`ifdef FEED_PERF_EN
      ,
      .perfCycles_o (perfCycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [ROWS*32-1:0] memWord(input logic [ADDR_W-1:0] a);
      logic [ROWS*32-1:0] w;
      for (int r = 0; r < ROWS; r++) w[r*32 +: 32] = {16'hC0DE, 2'b00, a, 4'(r)};
      return w;
   endfunction

   function automatic int readTile(input int c, input int n);
      int d;
      d = c - 1;
      if (d < 0 || d % BPW != 0 || d / BPW >= n) return -1;
      return d / BPW;
   endfunction

   function automatic int rowTile(input int c, input int n, input int r);
      int d;
      d = c - 2 - r;
      if (d < 0 || d % BPW != 0 || d / BPW >= n) return -1;
      return d / BPW;
   endfunction

   // Operand memory: registered read, data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.memRdEn) bus.memRdata <= memWord(bus.memAddr);
   end

   task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int n);
      @(negedge clk);
      bus.baseAddr = base;
      bus.numTiles = TILE_W'(n);
      bus.start    = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus.memRdEn, bus.memAddr, bus.rowEn, bus.rowWord, bus.busy, bus.done} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got=%h exp=0",
                  {bus.memRdEn, bus.memAddr, bus.rowEn, bus.rowWord, bus.busy, bus.done});
      end
      applyStimulus(10'h040, 3);
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (c == 4) begin
            checks++;
            if ({bus.memRdEn, bus.memAddr, bus.rowEn, bus.rowWord, bus.busy, bus.done} !== '0) begin
               errors++;
               $display("[TB] FAIL midrun_reset c=%0d got=%h exp=0", c,
                        {bus.memRdEn, bus.memAddr, bus.rowEn, bus.rowWord, bus.busy, bus.done});
            end
         end
         if (c >= 4) begin
            checks++;
            if ({bus.rowEn, bus.busy, bus.done, bus.memRdEn} !== '0) begin
               errors++;
               $display("[TB] FAIL after_reset_quiet c=%0d got=%h exp=0", c,
                        {bus.rowEn, bus.busy, bus.done, bus.memRdEn});
            end
         end
         if (c == 3) rst = 1'b1;
         if (c == 6) rst = 1'b0;
      end
   endtask

   task automatic test_basic();
      int t, rt, doneCnt, doneAt;
      int r2Cyc[$];
      logic [ROWS*32-1:0] w;
      doneCnt = 0;
      doneAt  = -1;
      applyStimulus(10'h010, 3);
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         t = readTile(c, 3);
         checks++;
         if (bus.memRdEn !== (t >= 0)) begin
            errors++;
            $display("[TB] FAIL basic_rden c=%0d got=%b exp=%b", c, bus.memRdEn, (t >= 0));
         end
         if (t >= 0) begin
            checks++;
            if (bus.memAddr !== ADDR_W'(10'h010 + t)) begin
               errors++;
               $display("[TB] FAIL basic_addr c=%0d got=%h exp=%h", c, bus.memAddr, 10'h010 + t);
            end
         end
         for (int r = 0; r < ROWS; r++) begin
            rt = rowTile(c, 3, r);
            checks++;
            if (bus.rowEn[r] !== (rt >= 0)) begin
               errors++;
               $display("[TB] FAIL basic_rowen r=%0d c=%0d got=%b exp=%b", r, c, bus.rowEn[r], (rt >= 0));
            end
            if (rt >= 0) begin
               w = memWord(ADDR_W'(10'h010 + rt));
               checks++;
               if (bus.rowWord[r*32 +: 32] !== w[r*32 +: 32]) begin
                  errors++;
                  $display("[TB] FAIL basic_rowword r=%0d c=%0d got=%h exp=%h", r, c,
                           bus.rowWord[r*32 +: 32], w[r*32 +: 32]);
               end
            end
         end
         if (bus.rowEn[2] === 1'b1) r2Cyc.push_back(c);
         checks++;
         if (bus.busy !== (c < 22)) begin
            errors++;
            $display("[TB] FAIL basic_busy c=%0d got=%b exp=%b", c, bus.busy, (c < 22));
         end
         if (bus.done === 1'b1) begin
            doneCnt++;
            doneAt = c;
         end
      end
      checks++;
      if (doneCnt != 1 || doneAt != 22) begin
         errors++;
         $display("[TB] FAIL basic_done count=%0d at=%0d exp count=1 at=22", doneCnt, doneAt);
      end
      checks++;
      if (r2Cyc.size() != 3 || r2Cyc[0] != 4 || r2Cyc[1] != 8 || r2Cyc[2] != 12) begin
         errors++;
         $display("[TB] FAIL basic_row2_cycles got=%p exp=4,8,12", r2Cyc);
      end
      w = memWord(10'h012);
      checks++;
      if (bus.rowWord[2*32 +: 32] !== w[2*32 +: 32]) begin
         errors++;
         $display("[TB] FAIL basic_hold got=%h exp=%h", bus.rowWord[2*32 +: 32], w[2*32 +: 32]);
      end
   endtask

   task automatic test_zero_tiles();
      applyStimulus(10'h050, 0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         checks++;
         if ({bus.done, bus.busy, bus.memRdEn} !== {(c == 1), 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zero_tiles c=%0d got done,busy,rden=%b exp=%b", c,
                     {bus.done, bus.busy, bus.memRdEn}, {(c == 1), 1'b0, 1'b0});
         end
      end
   endtask

   task automatic test_addr_wrap();
      logic [ROWS*32-1:0] w;
      applyStimulus(10'h3FF, 2);
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (c == 1 || c == 5) begin
            checks++;
            if (bus.memRdEn !== 1'b1 || bus.memAddr !== ((c == 1) ? 10'h3FF : 10'h000)) begin
               errors++;
               $display("[TB] FAIL wrap_addr c=%0d got rden=%b addr=%h exp addr=%h", c,
                        bus.memRdEn, bus.memAddr, (c == 1) ? 10'h3FF : 10'h000);
            end
         end
         if (c == 7) begin
            w = memWord(10'h000);
            checks++;
            if (bus.rowEn[1] !== 1'b1 || bus.rowWord[32 +: 32] !== w[32 +: 32]) begin
               errors++;
               $display("[TB] FAIL wrap_row1 got en=%b word=%h exp word=%h", bus.rowEn[1],
                        bus.rowWord[32 +: 32], w[32 +: 32]);
            end
         end
         if (c >= 17) begin
            checks++;
            if (bus.done !== (c == 18)) begin
               errors++;
               $display("[TB] FAIL wrap_done c=%0d got=%b exp=%b", c, bus.done, (c == 18));
            end
         end
      end
   endtask

   task automatic test_abort();
      logic [ROWS-1:0] expEn;
      logic [ROWS*32-1:0] w;
      int doneAt;
      doneAt = -1;
      applyStimulus(10'h020, 3);
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (c <= 6) begin
            for (int r = 0; r < ROWS; r++) expEn[r] = (rowTile(c, 3, r) >= 0);
            checks++;
            if (bus.rowEn !== expEn || bus.busy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL abort_prefix c=%0d got en=%b busy=%b exp en=%b busy=1", c,
                        bus.rowEn, bus.busy, expEn);
            end
         end else if (c <= 8) begin
            checks++;
            if ({bus.rowEn, bus.busy, bus.memRdEn, bus.done} !== '0) begin
               errors++;
               $display("[TB] FAIL abort_quiet c=%0d got=%b exp=0", c,
                        {bus.rowEn, bus.busy, bus.memRdEn, bus.done});
            end
         end else if (c == 9) begin
            bus.start = 1'b0;
            checks++;
            if (bus.busy !== 1'b1 || bus.memRdEn !== 1'b1 || bus.memAddr !== 10'h030) begin
               errors++;
               $display("[TB] FAIL abort_restart got busy=%b rden=%b addr=%h exp 1,1,030",
                        bus.busy, bus.memRdEn, bus.memAddr);
            end
         end else if (c == 10) begin
            w = memWord(10'h030);
            checks++;
            if (bus.rowEn !== 4'b0001 || bus.rowWord[31:0] !== w[31:0]) begin
               errors++;
               $display("[TB] FAIL abort_restart_row0 got en=%b word=%h exp en=0001 word=%h",
                        bus.rowEn, bus.rowWord[31:0], w[31:0]);
            end
         end
         if (bus.done === 1'b1 && doneAt < 0) doneAt = c;
         if (c == 6) bus.abort = 1'b1;
         if (c == 7) bus.abort = 1'b0;
         if (c == 8) begin
            bus.start    = 1'b1;
            bus.numTiles = 8'd1;
            bus.baseAddr = 10'h030;
         end
      end
      checks++;
      if (doneAt != 22) begin
         errors++;
         $display("[TB] FAIL abort_restart_done got at=%0d exp at=22", doneAt);
      end
      applyStimulus(10'h060, 2);
      bus.abort = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.abort = 1'b0;
         checks++;
         if ({bus.busy, bus.memRdEn, bus.done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL start_abort_same c=%0d got=%b exp=000", c,
                     {bus.busy, bus.memRdEn, bus.done});
         end
      end
   endtask

   task automatic test_back_to_back();
      int doneAt;
      doneAt = -1;
      applyStimulus(10'h100, 1);
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c == 1 || c == 4) bus.start = 1'b0;
         if (c <= 14) begin
            checks++;
            if ({bus.memRdEn, bus.busy, bus.done} !== {(c == 1), (c < 14), (c == 14)}) begin
               errors++;
               $display("[TB] FAIL busy_start_ignored c=%0d got rden,busy,done=%b exp=%b", c,
                        {bus.memRdEn, bus.busy, bus.done}, {(c == 1), (c < 14), (c == 14)});
            end
         end
         if (c == 3) begin
            bus.start    = 1'b1;
            bus.numTiles = 8'd5;
            bus.baseAddr = 10'h200;
         end
         if (c == 14) begin
            bus.start    = 1'b1;
            bus.numTiles = 8'd1;
            bus.baseAddr = 10'h150;
         end
         if (c == 15) begin
            bus.start = 1'b0;
            checks++;
            if (bus.busy !== 1'b1 || bus.memRdEn !== 1'b1 || bus.memAddr !== 10'h150) begin
               errors++;
               $display("[TB] FAIL back_to_back got busy=%b rden=%b addr=%h exp 1,1,150",
                        bus.busy, bus.memRdEn, bus.memAddr);
            end
         end
      end
      for (int c = 16; c <= 30 && doneAt < 0; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) doneAt = c;
      end
      checks++;
      if (doneAt != 28) begin
         errors++;
         $display("[TB] FAIL back_to_back_done got at=%0d exp at=28", doneAt);
      end
   endtask

`ifdef FEED_PERF_EN
   task automatic test_perf();
      int busyCnt;
      busyCnt = 0;
      applyStimulus(10'h070, 1);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (bus.busy === 1'b1) busyCnt++;
         if (c == 14 || c == 18) begin
            checks++;
            if (perfCycles !== 32'(busyCnt) || perfCycles !== 32'd13) begin
               errors++;
               $display("[TB] FAIL perf_cycles c=%0d got=%0d exp=%0d (busy seen %0d)", c,
                        perfCycles, 13, busyCnt);
            end
         end
      end
   endtask
`endif

   initial begin
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.baseAddr = '0;
      bus.numTiles = '0;
      bus.memRdata = '0;
      rst          = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_basic();
      test_zero_tiles();
      test_addr_wrap();
      test_abort();
      test_back_to_back();
`ifdef FEED_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
